// File: rtl/car_warning_ctrl.sv
// Seat-belt warning controller: sync + debounce door/ignition/belt switches, drive registered Alarm.
// Latency: a stable input change sampled at edge 1 reaches Alarm at edge SYNC_STAGES+DEB_CYCLES+1.
// Backpressure: none; free-running level-in/level-out block. Optional macro: ALARM_TIMEOUT_EN (auto-silence).
module car_warning_ctrl #(
    parameter int SYNC_STAGES    = 2,
    parameter int DEB_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic DoorClose,
    input  logic Ignition,
    input  logic SeatBelt,
    output logic Alarm
);

    // Debounce counter only needs to reach DEB_CYCLES-1 before the update edge.
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    // Bit order used throughout: [2] door closed, [1] ignition on, [0] belt fastened.
    logic [2:0]    w_raw;
    logic [2:0]    w_sync;
    logic          w_cond;
    logic [2:0]    r_sync [SYNC_STAGES];
    logic [2:0]    r_filt;
    logic [DW-1:0] r_deb_cnt [3];

    assign w_raw  = {DoorClose, Ignition, SeatBelt};
    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_cond = r_filt[2] & r_filt[1] & ~r_filt[0];

    // Multi-flop synchronisers bring the asynchronous switch levels into the Clk domain.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= w_raw;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    // Per-input debounce: filtered level moves only after DEB_CYCLES consecutive differing edges.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_filt <= '0;
            for (int i = 0; i < 3; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_sync[i] == r_filt[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_LAST) begin
                    r_filt[i]    <= w_sync[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef ALARM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] r_to_cnt;
    logic          r_silenced;

    // Alarm with auto-silence: after TIMEOUT_CYCLES alarm edges it drops until cond goes away.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_to_cnt   <= '0;
            r_silenced <= 1'b0;
            Alarm      <= 1'b0;
        end else if (!w_cond) begin
            // Condition gone: re-arm so the next unfastening gets the full timeout again.
            r_to_cnt   <= '0;
            r_silenced <= 1'b0;
            Alarm      <= 1'b0;
        end else if (r_silenced) begin
            Alarm      <= 1'b0;
        end else if (r_to_cnt == TLIM) begin
            // Counter holds at the limit; the flag keeps the alarm quiet.
            r_silenced <= 1'b1;
            Alarm      <= 1'b0;
        end else begin
            r_to_cnt   <= r_to_cnt + 1'b1;
            Alarm      <= 1'b1;
        end
    end
`else
    // Alarm is a plain registered copy of the condition, so it cannot glitch.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            Alarm <= 1'b0;
        end else begin
            Alarm <= w_cond;
        end
    end
`endif

endmodule

// File: tb/tb_car_warning_ctrl.sv
// Directed bench for car_warning_ctrl with defaults SYNC_STAGES=2, DEB_CYCLES=4 (7-edge latency).
// Inputs are driven and Alarm sampled 1 time unit after each rising edge.
// Timeout scenario is built only when ALARM_TIMEOUT_EN is defined (TIMEOUT_CYCLES=10).
module tb_car_warning_ctrl;

    logic Clk       = 1'b0;
    logic Rst_n     = 1'b0;
    logic DoorClose = 1'b0;
    logic Ignition  = 1'b0;
    logic SeatBelt  = 1'b0;
    logic Alarm;

    int vectors     = 0;
    int miscompares = 0;

    always #5 Clk = ~Clk;

    car_warning_ctrl #(
        .SYNC_STAGES   (2),
        .DEB_CYCLES    (4),
        .TIMEOUT_CYCLES(10)
    ) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .DoorClose(DoorClose),
        .Ignition (Ignition),
        .SeatBelt (SeatBelt),
        .Alarm    (Alarm)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic drive(input logic d, input logic i, input logic s);
        DoorClose = d;
        Ignition  = i;
        SeatBelt  = s;
    endtask

    // Reset held 3 edges with alarm-worthy inputs, then release and time the first alarm.
    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b0);
        Rst_n = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            tick(1);
            vectors++;
            if (Alarm !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hold edge %0d: Alarm=%b expected 0", e, Alarm);
            end
        end
        Rst_n = 1'b1;
        tick(6);
        vectors++;
        if (Alarm !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_edge6: Alarm=%b expected 0", Alarm);
        end
        tick(1);
        vectors++;
        if (Alarm !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_edge7: Alarm=%b expected 1", Alarm);
        end
    endtask

    // Truth-table walk; each change must land exactly on edge 7.
    task automatic test_walk();
        logic [2:0] pat [5];
        logic       exp [5];
        logic       prev;
        pat  = '{3'b100, 3'b000, 3'b010, 3'b110, 3'b111};
        exp  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        prev = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(pat[k][2], pat[k][1], pat[k][0]);
            tick(6);
            vectors++;
            if (Alarm !== prev) begin
                miscompares++;
                $display("FAIL walk%0d_edge6 in=%b: Alarm=%b expected %b", k, pat[k], Alarm, prev);
            end
            tick(1);
            vectors++;
            if (Alarm !== exp[k]) begin
                miscompares++;
                $display("FAIL walk%0d_edge7 in=%b: Alarm=%b expected %b", k, pat[k], Alarm, exp[k]);
            end
            tick(93);
            vectors++;
            if (Alarm !== exp[k]) begin
                miscompares++;
                $display("FAIL walk%0d_hold in=%b: Alarm=%b expected %b", k, pat[k], Alarm, exp[k]);
            end
            prev = exp[k];
        end
    endtask

    // Belt pulses: 3 cycles are filtered out, 4 cycles pass through for 4 cycles.
    task automatic test_glitch();
        int bad;
        bad = 0;
        drive(1'b1, 1'b1, 1'b0);
        tick(3);
        drive(1'b1, 1'b1, 1'b1);
        for (int c = 0; c < 20; c++) begin
            tick(1);
            if (Alarm !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL short_pulse: %0d cycles with Alarm high, expected 0", bad);
        end
        drive(1'b1, 1'b1, 1'b0);
        tick(4);
        drive(1'b1, 1'b1, 1'b1);
        tick(2);
        vectors++;
        if (Alarm !== 1'b0) begin
            miscompares++;
            $display("FAIL pulse4_edge6: Alarm=%b expected 0", Alarm);
        end
        tick(1);
        vectors++;
        if (Alarm !== 1'b1) begin
            miscompares++;
            $display("FAIL pulse4_edge7: Alarm=%b expected 1", Alarm);
        end
        tick(3);
        vectors++;
        if (Alarm !== 1'b1) begin
            miscompares++;
            $display("FAIL pulse4_edge10: Alarm=%b expected 1", Alarm);
        end
        tick(1);
        vectors++;
        if (Alarm !== 1'b0) begin
            miscompares++;
            $display("FAIL pulse4_edge11: Alarm=%b expected 0", Alarm);
        end
        tick(20);
    endtask

    // One-edge reset while alarming clears everything; alarm returns after full latency.
    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 1'b0);
        tick(7);
        vectors++;
        if (Alarm !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_pre: Alarm=%b expected 1", Alarm);
        end
        Rst_n = 1'b0;
        tick(1);
        vectors++;
        if (Alarm !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_edge: Alarm=%b expected 0", Alarm);
        end
        Rst_n = 1'b1;
        tick(6);
        vectors++;
        if (Alarm !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_edge6: Alarm=%b expected 0", Alarm);
        end
        tick(1);
        vectors++;
        if (Alarm !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_edge7: Alarm=%b expected 1", Alarm);
        end
    endtask

    // All three inputs flipping on the same edge filter together.
    task automatic test_back_to_back();
        drive(1'b0, 1'b0, 1'b1);
        tick(6);
        vectors++;
        if (Alarm !== 1'b1) begin
            miscompares++;
            $display("FAIL simul_off_edge6: Alarm=%b expected 1", Alarm);
        end
        tick(1);
        vectors++;
        if (Alarm !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_off_edge7: Alarm=%b expected 0", Alarm);
        end
        tick(20);
        drive(1'b1, 1'b1, 1'b0);
        tick(6);
        vectors++;
        if (Alarm !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_on_edge6: Alarm=%b expected 0", Alarm);
        end
        tick(1);
        vectors++;
        if (Alarm !== 1'b1) begin
            miscompares++;
            $display("FAIL simul_on_edge7: Alarm=%b expected 1", Alarm);
        end
    endtask

`ifdef ALARM_TIMEOUT_EN
    // Auto-silence after 10 alarm cycles, re-armed by fastening then unfastening.
    task automatic test_timeout();
        drive(1'b1, 1'b1, 1'b1);
        tick(20);
        for (int r = 0; r < 2; r++) begin
            drive(1'b1, 1'b1, 1'b0);
            tick(7);
            vectors++;
            if (Alarm !== 1'b1) begin
                miscompares++;
                $display("FAIL timeout%0d_start: Alarm=%b expected 1", r, Alarm);
            end
            tick(9);
            vectors++;
            if (Alarm !== 1'b1) begin
                miscompares++;
                $display("FAIL timeout%0d_cycle10: Alarm=%b expected 1", r, Alarm);
            end
            tick(1);
            vectors++;
            if (Alarm !== 1'b0) begin
                miscompares++;
                $display("FAIL timeout%0d_silenced: Alarm=%b expected 0", r, Alarm);
            end
            tick(50);
            vectors++;
            if (Alarm !== 1'b0) begin
                miscompares++;
                $display("FAIL timeout%0d_held: Alarm=%b expected 0", r, Alarm);
            end
            drive(1'b1, 1'b1, 1'b1);
            tick(20);
        end
    endtask
`else
    // Without the timeout feature the alarm never self-silences.
    task automatic test_no_timeout();
        int low;
        low = 0;
        drive(1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 5000; c++) begin
            tick(1);
            if (Alarm !== 1'b1) low++;
        end
        vectors++;
        if (low != 0) begin
            miscompares++;
            $display("FAIL no_timeout: %0d cycles with Alarm low, expected 0", low);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_walk();
        test_glitch();
        test_reset_mid();
        test_back_to_back();
`ifdef ALARM_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
